// File: rtl/status_report.sv
// Periodic / on-demand 8-byte status frame generator feeding a UART tx FIFO.
// Frame: EB 90 CK BA ST SQ 09 D7, one byte pushed every 4 clocks.

`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 8
`endif

module status_report #(
  parameter int unsigned PERIOD     = 32'd50_000_000,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            switch,
  input  logic                            power_on_A,
  input  logic                            power_on_B,
  input  logic                            reset_a_signal,
  input  logic                            reset_b_signal,
  input  logic                            error,
  input  logic                            send_req,
  input  logic [`UART_FIFO_COUNTER_W-1:0] tf_counter,
  output logic                            tf_push,
  output logic [7:0]                      tdr,
  output logic                            busy
);

  localparam int unsigned CW = `UART_FIFO_COUNTER_W;
  localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_LAST  = TW'(PERIOD - 1);
  // A frame is launched only when all 8 bytes fit in the FIFO.
  localparam logic [CW-1:0] SPACE_LIMIT = CW'(FIFO_DEPTH - 8);

  localparam logic [7:0] SYNC_0 = 8'hEB;
  localparam logic [7:0] SYNC_1 = 8'h90;
  localparam logic [7:0] ID     = 8'hBA;
  localparam logic [7:0] TAIL_0 = 8'h09;
  localparam logic [7:0] TAIL_1 = 8'hD7;

  typedef enum logic [4:0] {
    IDLE       = 5'b00001,
    WAIT_SPACE = 5'b00010,
    LOAD       = 5'b00100,
    SEND       = 5'b01000,
    GAP        = 5'b10000
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          timer_wrap;
  logic          pending;
  logic          err_sticky;
  logic [7:0]    seq;
  logic [7:0]    st_snap;
  logic [7:0]    sq_snap;
  logic [7:0]    ck;
  logic [3:0]    idx;
  logic [1:0]    gap_cnt;
  logic [7:0]    st_now;
  logic [7:0]    frame_byte;

  assign timer_wrap = (timer == TIMER_LAST);
  assign st_now = {2'b00, err_sticky, reset_b_signal, reset_a_signal,
                   power_on_B, power_on_A, switch};

  // Free-running report interval timer, 0..PERIOD-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (timer_wrap) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Single pending flag: requests and timer wraps coalesce; a set on the
  // LOAD cycle wins over the clear so that request is kept for the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (send_req || timer_wrap) begin
      pending <= 1'b1;
    end else if (state == LOAD) begin
      pending <= 1'b0;
    end
  end

  // Error latch reported in ST; new errors on the LOAD cycle survive the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (error) begin
      err_sticky <= 1'b1;
    end else if (state == LOAD) begin
      err_sticky <= 1'b0;
    end
  end

  // Byte selection from the snapshot taken at LOAD.
  always_comb begin
    frame_byte = TAIL_1;
    case (idx)
      4'd0:    frame_byte = SYNC_0;
      4'd1:    frame_byte = SYNC_1;
      4'd2:    frame_byte = ck;
      4'd3:    frame_byte = ID;
      4'd4:    frame_byte = st_snap;
      4'd5:    frame_byte = sq_snap;
      4'd6:    frame_byte = TAIL_0;
      default: frame_byte = TAIL_1;
    endcase
  end

  // Frame sequencer with registered outputs; the push registered in SEND is
  // visible during the first GAP cycle, giving a 4-cycle byte pitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      tf_push <= 1'b0;
      tdr     <= '0;
      busy    <= 1'b0;
      idx     <= '0;
      gap_cnt <= '0;
      st_snap <= '0;
      sq_snap <= '0;
      ck      <= '0;
      seq     <= '0;
    end else begin
      tf_push <= 1'b0;
      case (state)
        IDLE: begin
          if (pending || send_req) begin
            state <= WAIT_SPACE;
          end
        end
        WAIT_SPACE: begin
          if (tf_counter <= SPACE_LIMIT) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          st_snap <= st_now;
          sq_snap <= seq;
          ck      <= 8'h00 - ID - st_now - seq;
          idx     <= '0;
          state   <= SEND;
        end
        SEND: begin
          tdr     <= frame_byte;
          tf_push <= 1'b1;
          idx     <= idx + 4'd1;
          gap_cnt <= '0;
          state   <= GAP;
        end
        GAP: begin
          if (gap_cnt == 2'd2) begin
            if (idx == 4'd8) begin
              seq   <= seq + 8'd1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= SEND;
            end
          end else begin
            gap_cnt <= gap_cnt + 2'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_status_report.sv
// Bench for status_report: directed scenarios plus randomized snapshot
// inputs, checked against a frame model built from the byte-layout rules.

`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 8
`endif

module tb_status_report;
  localparam int unsigned CW = `UART_FIFO_COUNTER_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: long period, driven by requests
  logic          rst_n, sw, pa, pb, ra, rb, err, req;
  logic [CW-1:0] tfc;
  logic          push_a, busy_a;
  logic [7:0]    tdr_a;
  // DUT B: PERIOD=100, no requests, constant inputs
  logic          b_sw, b_pa, b_pb, b_ra, b_rb, b_err, b_req;
  logic [CW-1:0] b_tfc;
  logic          push_b, busy_b;
  logic [7:0]    tdr_b;

  status_report #(.PERIOD(1_000_000), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .switch(sw), .power_on_A(pa), .power_on_B(pb),
    .reset_a_signal(ra), .reset_b_signal(rb), .error(err), .send_req(req),
    .tf_counter(tfc), .tf_push(push_a), .tdr(tdr_a), .busy(busy_a)
  );

  status_report #(.PERIOD(100), .FIFO_DEPTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .switch(b_sw), .power_on_A(b_pa), .power_on_B(b_pb),
    .reset_a_signal(b_ra), .reset_b_signal(b_rb), .error(b_err), .send_req(b_req),
    .tf_counter(b_tfc), .tf_push(push_b), .tdr(tdr_b), .busy(busy_b)
  );

  typedef struct {
    int unsigned c;
    logic [7:0]  b;
  } push_t;

  push_t qa[$];
  push_t qb[$];
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;
  int unsigned dbl = 0;

  // Record every push with its cycle stamp, sampled mid-cycle.
  always @(negedge clk) begin
    if (push_a === 1'b1) begin
      qa.push_back('{c: cyc, b: tdr_a});
      if (prev_a === 1'b1) dbl++;
    end
    if (push_b === 1'b1) begin
      qb.push_back('{c: cyc, b: tdr_b});
      if (prev_b === 1'b1) dbl++;
    end
    prev_a = push_a;
    prev_b = push_b;
  end

  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic step(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned st_of(input bit s, input bit a, input bit b,
                                        input bit x, input bit y, input bit e);
    return s + 2 * a + 4 * b + 8 * x + 16 * y + 32 * e;
  endfunction

  // Checksum chosen so that CK + BA + ST + SQ is a multiple of 256.
  function automatic logic [63:0] frame_of(input int unsigned st, input int unsigned sq);
    int unsigned c;
    c = (256 - ((186 + st + sq) % 256)) % 256;
    return {8'hEB, 8'h90, 8'(c), 8'hBA, 8'(st), 8'(sq), 8'h09, 8'hD7};
  endfunction

  task automatic get_push(input bit from_b, output push_t p, output bit ok);
    p  = '{c: 0, b: 8'h00};
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (!from_b && qa.size() > 0) begin
        p = qa.pop_front(); ok = 1'b1; return;
      end
      if (from_b && qb.size() > 0) begin
        p = qb.pop_front(); ok = 1'b1; return;
      end
      step();
    end
  endtask

  task automatic check_frame(input string tag, input bit from_b, input int unsigned st,
                             input int unsigned sq, input bit chk_first,
                             input int unsigned first_c, output int unsigned last_c);
    logic [63:0] f;
    push_t p;
    bit ok;
    int unsigned prev_c;
    f = frame_of(st, sq);
    prev_c = 0;
    last_c = 0;
    for (int i = 0; i < 8; i++) begin
      get_push(from_b, p, ok);
      chk($sformatf("%s push%0d seen", tag, i), 32'(ok), 32'd1);
      if (!ok) return;
      chk($sformatf("%s byte%0d", tag, i), 32'(p.b), 32'(f[63 - 8 * i -: 8]));
      if (i == 0 && chk_first) chk($sformatf("%s first push cycle", tag), p.c, first_c);
      if (i > 0) chk($sformatf("%s spacing%0d", tag, i), p.c - prev_c, 32'd4);
      prev_c = p.c;
      last_c = p.c;
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && busy_a !== 1'b0; n++) step();
    chk("idle reached", 32'(busy_a), 32'd0);
  endtask

  task automatic pulse_req();
    req = 1'b1;
    step();
    req = 1'b0;
  endtask

  initial begin
    int unsigned r, k, t, lp, sq, st;
    bit err_p;

    rst_n = 1'b0; sw = 1'b1; pa = 1'b1; pb = 1'b1; ra = 1'b0; rb = 1'b0;
    err = 1'b0; req = 1'b0; tfc = '0;
    b_sw = 1'b1; b_pa = 1'b0; b_pb = 1'b1; b_ra = 1'b0; b_rb = 1'b0;
    b_err = 1'b0; b_req = 1'b0; b_tfc = '0;
    step(3);
    rst_n = 1'b1;
    r = cyc;
    chk("reset tf_push", 32'(push_a), 32'd0);
    chk("reset tdr", 32'(tdr_a), 32'd0);
    chk("reset busy", 32'(busy_a), 32'd0);
    chk("reset b tf_push", 32'(push_b), 32'd0);
    sq = 0;
    err_p = 1'b0;

    // Reference frame EB 90 3F BA 07 00 09 D7, latency 4
    step();
    k = cyc;
    pulse_req();
    check_frame("first frame", 1'b0, st_of(1, 1, 1, 0, 0, 0), sq, 1'b1, k + 4, lp);
    chk("busy on last gap", 32'(busy_a), 32'd1);
    if (cyc < lp + 4) step(lp + 4 - cyc);
    chk("busy after frame", 32'(busy_a), 32'd0);
    sq = 1;

    wait_idle();
    k = cyc;
    pulse_req();
    check_frame("second frame", 1'b0, st_of(1, 1, 1, 0, 0, 0), sq, 1'b1, k + 4, lp);
    sq = 2;

    // Random snapshot inputs and error pulses over the rest of the SQ range
    for (int n = 2; n < 256; n++) begin
      wait_idle();
      sw = 1'($urandom_range(0, 1)); pa = 1'($urandom_range(0, 1));
      pb = 1'($urandom_range(0, 1)); ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      tfc = CW'($urandom_range(0, 8));
      if ($urandom_range(0, 3) == 0) begin
        err = 1'b1; step(); err = 1'b0; err_p = 1'b1;
      end
      step();
      st = st_of(sw, pa, pb, ra, rb, err_p);
      k = cyc;
      pulse_req();
      check_frame($sformatf("rnd frame %0d", n), 1'b0, st, sq, 1'b1, k + 4, lp);
      err_p = 1'b0;
      sq = (sq + 1) % 256;
    end

    // SQ wrapped: CK back to 3F
    wait_idle();
    sw = 1'b1; pa = 1'b1; pb = 1'b1; ra = 1'b0; rb = 1'b0; tfc = '0;
    k = cyc;
    pulse_req();
    check_frame("wrap frame", 1'b0, st_of(1, 1, 1, 0, 0, 0), sq, 1'b1, k + 4, lp);
    sq = (sq + 1) % 256;

    // FIFO nearly full holds the frame off
    wait_idle();
    tfc = CW'(9);
    pulse_req();
    step(20);
    chk("no push while fifo full", 32'(qa.size()), 32'd0);
    tfc = CW'(8);
    t = cyc;
    check_frame("fifo space frame", 1'b0, 7, sq, 1'b1, t + 3, lp);
    tfc = '0;
    sq++;

    // Error during frame N shows up in N+1 only
    wait_idle();
    k = cyc;
    pulse_req();
    step(9);
    err = 1'b1; step(); err = 1'b0;
    check_frame("err frame N", 1'b0, 7, sq, 1'b1, k + 4, lp);
    sq++;
    wait_idle();
    k = cyc;
    pulse_req();
    check_frame("err frame N+1", 1'b0, 7 + 32, sq, 1'b1, k + 4, lp);
    sq++;
    wait_idle();
    k = cyc;
    pulse_req();
    check_frame("err frame N+2", 1'b0, 7, sq, 1'b1, k + 4, lp);
    sq++;

    // Three requests during a frame coalesce into one more frame
    wait_idle();
    k = cyc;
    pulse_req();
    step(5);
    pulse_req();
    step(3);
    chk("busy mid frame", 32'(busy_a), 32'd1);
    pulse_req();
    step(6);
    pulse_req();
    check_frame("coalesce frame", 1'b0, 7, sq, 1'b1, k + 4, lp);
    sq++;
    check_frame("coalesced extra", 1'b0, 7, sq, 1'b0, 0, lp);
    sq++;
    step(60);
    chk("no third frame", 32'(qa.size()), 32'd0);

    // Request on the LOAD cycle is kept for the next frame
    wait_idle();
    k = cyc;
    pulse_req();
    step(1);
    pulse_req();
    check_frame("load req frame", 1'b0, 7, sq, 1'b1, k + 4, lp);
    sq++;
    check_frame("load req next", 1'b0, 7, sq, 1'b0, 0, lp);
    sq++;
    step(60);
    chk("load req single extra", 32'(qa.size()), 32'd0);

    // Reset after the 3rd byte aborts the frame
    wait_idle();
    k = cyc;
    pulse_req();
    step(12);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step(50);
    chk("pushes before abort", 32'(qa.size()), 32'd3);
    chk("busy after abort", 32'(busy_a), 32'd0);
    chk("tdr after abort", 32'(tdr_a), 32'd0);
    qa.delete();
    sq = 0;
    k = cyc;
    pulse_req();
    check_frame("post abort frame", 1'b0, 7, sq, 1'b1, k + 4, lp);

    // Periodic frames from DUT B recorded since the first reset release
    for (int j = 0; j < 3; j++) begin
      check_frame($sformatf("periodic frame %0d", j), 1'b1, st_of(1, 0, 1, 0, 0, 0),
                  j, 1'b1, r + 104 + 100 * j, lp);
    end

    chk("no back-to-back push", dbl, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
